stage_shuffle_buffer: RTL and testbench

Inter-stage coefficient reorder buffer placed directly downstream of a `bf_unit` output stream and upstream of the next stage's `bf_unit` input FIFO. It absorbs one frame of 256 coefficients (128 two-coefficient tokens), then re-emits them paired at distance 2^stride_log2 so the next butterfly stage receives the correct operand pairs. It is double-buffered (ping-pong), so it sustains one token per cycle in and out.

---
 rtl/ntt_stream_pkg.sv | 31 +++
 rtl/stage_shuffle_addr_gen.sv | 25 ++
 rtl/stage_shuffle_buffer.sv | 147 ++++++++++++++
 tb/tb_stage_shuffle_buffer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_stream_pkg.sv
// Shared stream definitions for the NTT butterfly pipeline: widths, token
// field positions and the ping-pong bank state encoding.
package ntt_stream_pkg;

    localparam int DATA_W       = 32;
    localparam int TOKEN_W      = 2 * DATA_W + 1;
    localparam int FRAME_COEFFS = 256;
    localparam int ADDR_W       = $clog2(FRAME_COEFFS);
    localparam int TOK_CNT_W    = ADDR_W - 1;
    localparam int P_W          = 3;

    localparam int TOK_LO_LSB = 0;
    localparam int TOK_HI_LSB = DATA_W;
    localparam int TOK_LAST   = 2 * DATA_W;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_e;

    // Out-of-range strides collapse to the widest legal pairing distance.
    function automatic logic [P_W-1:0] clamp_stride(input logic [P_W-1:0] s);
        if (int'(s) > ADDR_W - 1) begin
            return P_W'(ADDR_W - 1);
        end
        return s;
    endfunction

endpackage

// File: rtl/stage_shuffle_addr_gen.sv
// Maps output token index k and pairing exponent p to the operand addresses
// a = {k[6:p], 0, k[p-1:0]} and b = a | (1 << p).
module stage_shuffle_addr_gen
    import ntt_stream_pkg::*;
(
    input  logic [TOK_CNT_W-1:0] k,
    input  logic [P_W-1:0]       p,
    output logic [ADDR_W-1:0]    a,
    output logic [ADDR_W-1:0]    b
);

    logic [ADDR_W-1:0] k_ext;
    logic [ADDR_W-1:0] bit_p;
    logic [ADDR_W-1:0] low_mask;

    // Insert a zero at bit position p by shifting only the bits above it.
    always_comb begin
        k_ext    = {1'b0, k};
        bit_p    = ADDR_W'(1) << p;
        low_mask = bit_p - ADDR_W'(1);
        a        = ((k_ext & ~low_mask) << 1) | (k_ext & low_mask);
        b        = a | bit_p;
    end

endmodule

// File: rtl/stage_shuffle_buffer.sv
// Ping-pong reorder buffer between butterfly stages: absorbs a 256-coefficient
// frame in order and re-emits it paired at distance 2^p.
// Optional last-bit framing check enabled by STAGE_SHUFFLE_LAST_CHECK_EN.
module stage_shuffle_buffer
    import ntt_stream_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [P_W-1:0]     stride_log2,
    input  logic [TOKEN_W-1:0] in_s_dout,
    input  logic               in_s_empty_n,
    output logic               in_s_read,
    output logic [TOKEN_W-1:0] out_s_din,
    input  logic               out_s_full_n,
    output logic               out_s_write,
    output logic               busy,
    output logic               frame_err
);

    localparam logic [TOK_CNT_W-1:0] LAST_TOK = '1;

    bank_state_e          bank_state_q [2];
    bank_state_e          bank_state_d [2];
    logic [P_W-1:0]       bank_p_q [2];
    logic [P_W-1:0]       bank_p_d [2];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [TOK_CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [TOK_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [DATA_W-1:0]    mem_q [2][FRAME_COEFFS];

    logic                 wr_open;
    logic                 rd_active;
    logic [ADDR_W-1:0]    rd_addr_a;
    logic [ADDR_W-1:0]    rd_addr_b;

    stage_shuffle_addr_gen u_addr_gen (
        .k (rd_cnt_q),
        .p (bank_p_q[rd_ptr_q]),
        .a (rd_addr_a),
        .b (rd_addr_b)
    );

    // A FULL bank is drained in the same cycle it is selected, giving the
    // one-cycle turnaround from the final pop to the first push.
    always_comb begin
        wr_open     = (bank_state_q[wr_ptr_q] == BANK_EMPTY) ||
                      (bank_state_q[wr_ptr_q] == BANK_FILLING);
        rd_active   = (bank_state_q[rd_ptr_q] == BANK_FULL) ||
                      (bank_state_q[rd_ptr_q] == BANK_DRAINING);
        in_s_read   = !reset && in_s_empty_n && wr_open;
        out_s_write = !reset && rd_active && out_s_full_n;
        out_s_din   = '0;
        if (rd_active) begin
            out_s_din = {rd_cnt_q == LAST_TOK,
                         mem_q[rd_ptr_q][rd_addr_b],
                         mem_q[rd_ptr_q][rd_addr_a]};
        end
        busy = (bank_state_q[0] != BANK_EMPTY) || (bank_state_q[1] != BANK_EMPTY);
    end

    always_comb begin
        bank_state_d = bank_state_q;
        bank_p_d     = bank_p_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        if (in_s_read) begin
            wr_cnt_d = wr_cnt_q + TOK_CNT_W'(1);
            if (bank_state_q[wr_ptr_q] == BANK_EMPTY) begin
                bank_state_d[wr_ptr_q] = BANK_FILLING;
                bank_p_d[wr_ptr_q]     = clamp_stride(stride_log2);
            end
            if (wr_cnt_q == LAST_TOK) begin
                bank_state_d[wr_ptr_q] = BANK_FULL;
                wr_ptr_d               = !wr_ptr_q;
            end
        end
        // Write and read sides never act on the same bank state, so both
        // transitions can land in one cycle.
        if (bank_state_q[rd_ptr_q] == BANK_FULL) begin
            bank_state_d[rd_ptr_q] = BANK_DRAINING;
        end
        if (out_s_write) begin
            rd_cnt_d = rd_cnt_q + TOK_CNT_W'(1);
            if (rd_cnt_q == LAST_TOK) begin
                bank_state_d[rd_ptr_q] = BANK_EMPTY;
                rd_ptr_d               = !rd_ptr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_state_q[0] <= BANK_EMPTY;
            bank_state_q[1] <= BANK_EMPTY;
            bank_p_q[0]     <= '0;
            bank_p_q[1]     <= '0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            wr_cnt_q        <= '0;
            rd_cnt_q        <= '0;
        end else begin
            bank_state_q <= bank_state_d;
            bank_p_q     <= bank_p_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
        end
    end

    // Storage needs no reset: bank states gate every read of stale contents.
    always_ff @(posedge clk) begin
        if (in_s_read) begin
            mem_q[wr_ptr_q][{wr_cnt_q, 1'b0}] <= in_s_dout[TOK_LO_LSB +: DATA_W];
            mem_q[wr_ptr_q][{wr_cnt_q, 1'b1}] <= in_s_dout[TOK_HI_LSB +: DATA_W];
        end
    end

`ifdef STAGE_SHUFFLE_LAST_CHECK_EN
    logic frame_err_q, frame_err_d;

    always_comb begin
        frame_err_d = frame_err_q;
        if (in_s_read && (in_s_dout[TOK_LAST] != (wr_cnt_q == LAST_TOK))) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`else
    logic last_unused;
    assign last_unused = in_s_dout[TOK_LAST];
    assign frame_err   = 1'b0;
`endif

endmodule

// File: tb/tb_stage_shuffle_buffer.sv
// Directed self-checking bench for stage_shuffle_buffer: stride orders,
// back-to-back frames with output backpressure, framing error and mid-frame reset.
module tb_stage_shuffle_buffer;
    import ntt_stream_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic [P_W-1:0]     stride_log2;
    logic [TOKEN_W-1:0] in_s_dout;
    logic               in_s_empty_n;
    logic               in_s_read;
    logic [TOKEN_W-1:0] out_s_din;
    logic               out_s_full_n;
    logic               out_s_write;
    logic               busy;
    logic               frame_err;

    logic [TOKEN_W-1:0] in_q [$];
    logic [TOKEN_W-1:0] out_q [$];
    logic [TOKEN_W-1:0] exp_q [$];
    int                 pop_cyc [$];
    int                 out_cyc [$];
    int                 err_cyc;
    logic [DATA_W-1:0]  coef [FRAME_COEFFS];

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    stage_shuffle_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .stride_log2  (stride_log2),
        .in_s_dout    (in_s_dout),
        .in_s_empty_n (in_s_empty_n),
        .in_s_read    (in_s_read),
        .out_s_din    (out_s_din),
        .out_s_full_n (out_s_full_n),
        .out_s_write  (out_s_write),
        .busy         (busy),
        .frame_err    (frame_err)
    );

    // Queue one frame of input tokens built from coef[]; last marks i=127
    // and optionally an extra erroneous index.
    task automatic push_frame(input int bad_last_idx);
        for (int i = 0; i < FRAME_COEFFS / 2; i++) begin
            in_q.push_back({(i == 127) || (i == bad_last_idx), coef[2*i+1], coef[2*i]});
        end
    endtask

    function automatic logic [TOKEN_W-1:0] shuffled(input int k, input int p);
        int a, b;
        a = ((k >> p) << (p + 1)) | (k & ((1 << p) - 1));
        b = a + (1 << p);
        return {(k == 127), coef[b], coef[a]};
    endfunction

    task automatic push_expected(input int p);
        for (int k = 0; k < FRAME_COEFFS / 2; k++) exp_q.push_back(shuffled(k, p));
    endtask

    // Drives in_q into the DUT and records every push, pop and first frame_err.
    task automatic run_stream(input int n_out, input bit toggle_full, input int max_cycles);
        int cyc    = 0;
        int in_idx = 0;
        out_q.delete();
        out_cyc.delete();
        pop_cyc.delete();
        err_cyc = -1;
        while (out_q.size() < n_out && cyc < max_cycles) begin
            @(negedge clk);
            in_s_empty_n = (in_idx < in_q.size());
            in_s_dout    = in_s_empty_n ? in_q[in_idx] : '0;
            out_s_full_n = toggle_full ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (in_s_read) begin
                pop_cyc.push_back(cyc);
                in_idx++;
            end
            if (out_s_write) begin
                out_q.push_back(out_s_din);
                out_cyc.push_back(cyc);
            end
            if (frame_err === 1'b1 && err_cyc < 0) err_cyc = cyc;
            cyc++;
        end
        @(negedge clk);
        in_s_empty_n = 1'b0;
        in_s_dout    = '0;
        out_s_full_n = 1'b1;
        #1;
    endtask

    task automatic compare_stream(input string name);
        logic [TOKEN_W-1:0] got;
        checks_total++;
        if (out_q.size() !== exp_q.size()) begin
            $display("[TB] FAIL %s count: got %0d tokens, expected %0d", name, out_q.size(), exp_q.size());
        end else checks_passed++;
        for (int k = 0; k < exp_q.size(); k++) begin
            got = (k < out_q.size()) ? out_q[k] : 'x;
            checks_total++;
            if (got !== exp_q[k]) begin
                $display("[TB] FAIL %s token %0d: got %h, expected %h", name, k, got, exp_q[k]);
            end else checks_passed++;
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        in_s_empty_n = 1'b1;
        in_s_dout    = '0;
        out_s_full_n = 1'b1;
        stride_log2  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks_total += 5;
        if (in_s_read !== 1'b0) $display("[TB] FAIL reset in_s_read: got %b, expected 0", in_s_read);
        else checks_passed++;
        if (out_s_write !== 1'b0) $display("[TB] FAIL reset out_s_write: got %b, expected 0", out_s_write);
        else checks_passed++;
        if (out_s_din !== '0) $display("[TB] FAIL reset out_s_din: got %h, expected 0", out_s_din);
        else checks_passed++;
        if (busy !== 1'b0) $display("[TB] FAIL reset busy: got %b, expected 0", busy);
        else checks_passed++;
        if (frame_err !== 1'b0) $display("[TB] FAIL reset frame_err: got %b, expected 0", frame_err);
        else checks_passed++;
        reset        = 1'b0;
        in_s_empty_n = 1'b0;
    endtask

    task automatic test_identity();
        in_q.delete();
        exp_q.delete();
        for (int j = 0; j < FRAME_COEFFS; j++) coef[j] = DATA_W'(j);
        push_frame(-1);
        for (int k = 0; k < 128; k++) exp_q.push_back({(k == 127), DATA_W'(2*k+1), DATA_W'(2*k)});
        stride_log2 = 3'd0;
        run_stream(128, 1'b0, 1000);
        compare_stream("p0");
        checks_total += 3;
        if (out_cyc[0] !== pop_cyc[127] + 1)
            $display("[TB] FAIL p0 latency: first push cycle %0d, expected %0d", out_cyc[0], pop_cyc[127] + 1);
        else checks_passed++;
        if (out_cyc[127] - out_cyc[0] !== 127)
            $display("[TB] FAIL p0 burst span: got %0d cycles, expected 127", out_cyc[127] - out_cyc[0]);
        else checks_passed++;
        if (busy !== 1'b0) $display("[TB] FAIL p0 busy after drain: got %b, expected 0", busy);
        else checks_passed++;
    endtask

    task automatic test_stride7();
        in_q.delete();
        exp_q.delete();
        for (int j = 0; j < FRAME_COEFFS; j++) coef[j] = DATA_W'(j);
        push_frame(-1);
        for (int k = 0; k < 128; k++) exp_q.push_back({(k == 127), DATA_W'(k + 128), DATA_W'(k)});
        stride_log2 = 3'd7;
        run_stream(128, 1'b0, 1000);
        compare_stream("p7");
        checks_total++;
        if (out_q[127] !== {1'b1, 32'd255, 32'd127})
            $display("[TB] FAIL p7 token 127: got %h, expected %h", out_q[127], {1'b1, 32'd255, 32'd127});
        else checks_passed++;
    endtask

    task automatic test_stride1();
        in_q.delete();
        exp_q.delete();
        for (int j = 0; j < FRAME_COEFFS; j++) coef[j] = 32'd3221225472 - DATA_W'(j);
        push_frame(-1);
        push_expected(1);
        stride_log2 = 3'd1;
        run_stream(128, 1'b0, 1000);
        compare_stream("p1");
        checks_total += 2;
        if (out_q[0] !== {1'b0, 32'd3221225470, 32'd3221225472})
            $display("[TB] FAIL p1 token 0: got %h, expected %h", out_q[0], {1'b0, 32'd3221225470, 32'd3221225472});
        else checks_passed++;
        if (out_q[1] !== {1'b0, 32'd3221225469, 32'd3221225471})
            $display("[TB] FAIL p1 token 1: got %h, expected %h", out_q[1], {1'b0, 32'd3221225469, 32'd3221225471});
        else checks_passed++;
    endtask

    task automatic test_back_to_back();
        in_q.delete();
        exp_q.delete();
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < FRAME_COEFFS; j++) coef[j] = DATA_W'(f * 1000 + j * 3);
            push_frame(-1);
            push_expected(3);
        end
        stride_log2 = 3'd3;
        run_stream(384, 1'b1, 2000);
        compare_stream("b2b");
        checks_total += 3;
        if (pop_cyc[255] - pop_cyc[0] !== 255)
            $display("[TB] FAIL b2b two-frame fill span: got %0d, expected 255", pop_cyc[255] - pop_cyc[0]);
        else checks_passed++;
        if (pop_cyc[256] !== 383)
            $display("[TB] FAIL b2b third frame first pop: cycle %0d, expected 383", pop_cyc[256]);
        else checks_passed++;
        if (busy !== 1'b0) $display("[TB] FAIL b2b busy after drain: got %b, expected 0", busy);
        else checks_passed++;
    endtask

    task automatic test_frame_err();
        in_q.delete();
        exp_q.delete();
        for (int j = 0; j < FRAME_COEFFS; j++) coef[j] = DATA_W'(j + 1000);
        push_frame(5);
        push_expected(0);
        stride_log2 = 3'd0;
        run_stream(128, 1'b0, 1000);
        compare_stream("ferr");
`ifdef STAGE_SHUFFLE_LAST_CHECK_EN
        checks_total += 2;
        if (err_cyc !== pop_cyc[5] + 1)
            $display("[TB] FAIL ferr onset: cycle %0d, expected %0d", err_cyc, pop_cyc[5] + 1);
        else checks_passed++;
        if (frame_err !== 1'b1) $display("[TB] FAIL ferr sticky: got %b, expected 1", frame_err);
        else checks_passed++;
`else
        checks_total += 2;
        if (err_cyc !== -1) $display("[TB] FAIL ferr disabled onset: cycle %0d, expected none", err_cyc);
        else checks_passed++;
        if (frame_err !== 1'b0) $display("[TB] FAIL ferr disabled level: got %b, expected 0", frame_err);
        else checks_passed++;
`endif
    endtask

    task automatic test_reset_mid_frame();
        int pops = 0;
        for (int j = 0; j < FRAME_COEFFS; j++) coef[j] = DATA_W'(j * 5 + 11);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            in_s_empty_n = 1'b1;
            in_s_dout    = {1'b0, coef[2*i+1], coef[2*i]};
            #1;
            if (in_s_read) pops++;
        end
        @(negedge clk);
        in_s_dout = {1'b0, coef[121], coef[120]};
        #1;
        checks_total += 2;
        if (pops !== 60) $display("[TB] FAIL midreset pops before reset: got %0d, expected 60", pops);
        else checks_passed++;
        if (busy !== 1'b1) $display("[TB] FAIL midreset busy while filling: got %b, expected 1", busy);
        else checks_passed++;
        reset = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        in_s_empty_n = 1'b0;
        #1;
        checks_total += 5;
        if (in_s_read !== 1'b0) $display("[TB] FAIL midreset in_s_read: got %b, expected 0", in_s_read);
        else checks_passed++;
        if (out_s_write !== 1'b0) $display("[TB] FAIL midreset out_s_write: got %b, expected 0", out_s_write);
        else checks_passed++;
        if (out_s_din !== '0) $display("[TB] FAIL midreset out_s_din: got %h, expected 0", out_s_din);
        else checks_passed++;
        if (busy !== 1'b0) $display("[TB] FAIL midreset busy: got %b, expected 0", busy);
        else checks_passed++;
        if (frame_err !== 1'b0) $display("[TB] FAIL midreset frame_err: got %b, expected 0", frame_err);
        else checks_passed++;
        in_q.delete();
        exp_q.delete();
        push_frame(-1);
        push_expected(2);
        stride_log2 = 3'd2;
        run_stream(128, 1'b0, 1000);
        compare_stream("post_reset");
    endtask

    initial begin
        test_reset();
        test_identity();
        test_stride7();
        test_stride1();
        test_back_to_back();
        test_frame_err();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
